// File: rtl/ecc_pkg.sv
// Shared GF(2^7) point-multiplier definitions: field/point widths, generator, infinity encoding, FSM states.
// Points are packed {y, x} with x in the lower M bits.
package ecc_pkg;

  localparam int M  = 7;
  localparam int PW = 2 * M;

  localparam logic [PW-1:0] G       = 14'b11101111000001;
  localparam logic [PW-1:0] INF     = '0;
  localparam logic [7:0]    TIMEOUT = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    START1,
    DROP1,
    WAIT1,
    START2,
    DROP2,
    WAIT2,
    FIN
  } state_e;

  function automatic logic [M-1:0] point_x(input logic [PW-1:0] p);
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] point_y(input logic [PW-1:0] p);
    return p[PW-1:M];
  endfunction

endpackage

// File: rtl/ecdh_sequencer_if.sv
// Host request/response and point-multiplier start/done signals of the ECDH sequencer.
// slave is the sequencer's view; master is the host plus multiplier side.
interface ecdh_sequencer_if;
  import ecc_pkg::*;

  logic          req;
  logic [M-1:0]  priv_key;
  logic [PW-1:0] peer_point;
  logic          busy;
  logic [PW-1:0] pub_key;
  logic [PW-1:0] shared;
  logic          valid;
  logic          err;
  logic [PW-1:0] pm_point;
  logic [M-1:0]  pm_scalar;
  logic          pm_start;
  logic [PW-1:0] pm_result;
  logic          pm_done;

  modport slave (
    input  req, priv_key, peer_point, pm_result, pm_done,
    output busy, pub_key, shared, valid, err, pm_point, pm_scalar, pm_start
  );

  modport master (
    output req, priv_key, peer_point, pm_result, pm_done,
    input  busy, pub_key, shared, valid, err, pm_point, pm_scalar, pm_start
  );

endinterface

// File: rtl/ecdh_sequencer.sv
// ECDH initiator: runs k*G then k*P on the point multiplier, with input checks, watchdog and result check.
// All outputs registered; valid ~2*(L+2)+1 cycles after req; req while busy is dropped, never queued.
module ecdh_sequencer
  import ecc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ecdh_sequencer_if.slave bus
);

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic          p_inf_q, p_inf_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic [PW-1:0] pub_q, pub_d;
  logic [PW-1:0] shared_q, shared_d;
  logic [PW-1:0] pt_q, pt_d;
  logic [M-1:0]  sc_q, sc_d;
  logic          expired;
  logic          peer_inf;

  // Counter value that would reach TIMEOUT on this increment.
  assign expired  = (wdog_q == TIMEOUT - 8'd1);
  assign peer_inf = (point_x(bus.peer_point) == '0) && (point_y(bus.peer_point) == '0);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    p_inf_d  = p_inf_q;
    wdog_d   = wdog_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    start_d  = 1'b0;
    pub_d    = pub_q;
    shared_d = shared_q;
    pt_d     = pt_q;
    sc_d     = sc_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          p_d      = bus.peer_point;
          p_inf_d  = peer_inf;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          pub_d    = INF;
          shared_d = INF;
          if (bus.priv_key == '0) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            start_d = 1'b1;
            pt_d    = G;
            sc_d    = bus.priv_key;
            state_d = START1;
          end
        end
      end

      START1, START2: begin
        wdog_d  = '0;
        state_d = (state_q == START1) ? DROP1 : DROP2;
      end

      // A done still high from the previous operation must fall before WAIT trusts it.
      DROP1, DROP2: begin
        wdog_d = wdog_q + 8'd1;
        if (!bus.pm_done) begin
          state_d = (state_q == DROP1) ? WAIT1 : WAIT2;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = FIN;
          if (state_q == DROP1) pub_d = INF;
          else                  shared_d = INF;
        end
      end

      WAIT1: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.pm_done) begin
          pub_d = bus.pm_result;
          if (p_inf_q) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            start_d = 1'b1;
            pt_d    = p_q;
            state_d = START2;
          end
        end else if (expired) begin
          pub_d   = INF;
          err_d   = 1'b1;
          state_d = FIN;
        end
      end

      WAIT2: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.pm_done) begin
          shared_d = bus.pm_result;
          if (bus.pm_result == INF) err_d = 1'b1;
          state_d = FIN;
        end else if (expired) begin
          shared_d = INF;
          err_d    = 1'b1;
          state_d  = FIN;
        end
      end

      FIN: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      p_inf_q  <= 1'b0;
      wdog_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      pub_q    <= '0;
      shared_q <= '0;
      pt_q     <= '0;
      sc_q     <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      p_inf_q  <= p_inf_d;
      wdog_q   <= wdog_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      start_q  <= start_d;
      pub_q    <= pub_d;
      shared_q <= shared_d;
      pt_q     <= pt_d;
      sc_q     <= sc_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.pub_key   = pub_q;
  assign bus.shared    = shared_q;
  assign bus.pm_start  = start_q;
  assign bus.pm_point  = pt_q;
  assign bus.pm_scalar = sc_q;

endmodule
